// File: rtl/doodle_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the frame FSM state encoding, PS/2 prefix bytes and HID usage codes.
// No logic; imported by the receiver and its translation sub-module.
package doodle_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // HID usage codes produced by the translator
  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;

endpackage

// File: rtl/ps2_to_hid.sv
// Translates a PS/2 set-2 scancode (with extended prefix flag) to a HID usage code.
// Latency: purely combinational.
// Backpressure: none; unmapped codes yield 00.
module ps2_to_hid
  import doodle_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic [7:0] hid
);

  // Lookup keyed on {ext, code} so E0-prefixed keys are distinct
  always_comb begin
    hid = HID_NONE;
    case ({ext, code})
      9'h01C:  hid = HID_A;
      9'h023:  hid = HID_D;
      9'h01D:  hid = HID_W;
      9'h01B:  hid = HID_S;
      9'h029:  hid = HID_SPACE;
      9'h05A:  hid = HID_ENTER;
      9'h16B:  hid = HID_LEFT;
      9'h174:  hid = HID_RIGHT;
      9'h175:  hid = HID_UP;
      9'h172:  hid = HID_DOWN;
      default: hid = HID_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: decodes frames and tracks the single held key as a HID code.
// Latency: Keycode updates 1 cycle after the synchronised stop-bit edge; key_valid 1 cycle later.
// Backpressure: none; the keyboard cannot be stalled, frames are consumed as they arrive.
module ps2_keycode_rx
  import doodle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] Keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic       clk_s1_q, clk_s2_q, clk_prev_q;
  logic       dat_s1_q, dat_s2_q;
  ps2_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [7:0] keycode_q, keycode_d;
  logic       kv_pend_q, kv_pend_d;
  logic       key_valid_q;
  logic       frame_err_q, frame_err_d;

  logic       fall;
  logic       timeout_hit;
  logic       byte_ok;
  logic [7:0] hid;

  // Falling edge of the synchronised PS/2 clock (previous 1, current 0)
  assign fall = clk_prev_q & ~clk_s2_q;

  // Abort only after TIMEOUT_CYCLES full cycles with no edge while mid-frame
  assign timeout_hit = (state_q != ST_IDLE) && !fall &&
                       (tout_q == TW'(TIMEOUT_CYCLES - 1));

  // Translation sees the assembled byte and the current extended flag
  ps2_to_hid u_ps2_to_hid (
    .ext  (ext_q),
    .code (shift_q),
    .hid  (hid)
  );

  // Two-flop synchronisers plus edge-history flop; idle level of the bus is high
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // Frame, prefix and key state registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      tout_q      <= '0;
      keycode_q   <= HID_NONE;
      kv_pend_q   <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      tout_q      <= tout_d;
      keycode_q   <= keycode_d;
      kv_pend_q   <= kv_pend_d;
      key_valid_q <= kv_pend_q;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame FSM next-state, byte completion and key tracking
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    keycode_d   = keycode_q;
    kv_pend_d   = 1'b0;
    frame_err_d = 1'b0;
    byte_ok     = 1'b0;

    // Watchdog counts idle cycles only while a frame is in flight
    if (state_q == ST_IDLE || fall) tout_d = '0;
    else                            tout_d = tout_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) begin
            byte_ok = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (byte_ok) begin
      if (shift_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Only mapped keys can touch Keycode; repeats and foreign breaks are silent
        if (hid != HID_NONE) begin
          if (!brk_q && hid != keycode_q) begin
            keycode_d = hid;
            kv_pend_d = 1'b1;
          end else if (brk_q && hid == keycode_q) begin
            keycode_d = HID_NONE;
            kv_pend_d = 1'b1;
          end
        end
      end
    end

    if (timeout_hit) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end
  end

  assign Keycode   = keycode_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: table of single frames plus hand sequences.
module tb_ps2_keycode_rx;
  import doodle_pkg::*;

  localparam int HALF = 20;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] Keycode;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(5000)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .Keycode   (Keycode),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int chg_cyc = 0;
  int valid_cyc = 0;
  logic [7:0] kc_prev = 8'h00;
  int stop_cyc = 0;

  int checks = 0;
  int errors = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (key_valid) begin
      vcnt      <= vcnt + 1;
      valid_cyc <= cyc;
    end
    if (frame_err) ecnt <= ecnt + 1;
    if (Keycode != kc_prev) chg_cyc <= cyc;
    kc_prev <= Keycode;
  end

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_kc;
    int         dv;
    int         de;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] c, input bit bp, input bit bs,
                     input logic [7:0] kc, input int dv, input int de);
    vec_t v;
    v.code = c; v.bad_par = bp; v.bad_stop = bs;
    v.exp_kc = kc; v.dv = dv; v.de = de;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Drives the first nbits of a frame: start, 8 data LSB first, odd parity, stop
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = (~^b) ^ bad_par;
    bits[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    cycles(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  initial begin
    int v0, e0;

    Reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cycles(5);
    chk("reset_keycode", Keycode, 8'h00);
    chk("reset_key_valid", key_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    Reset = 1'b1;
    cycles(10);

    // First make: check exact latency from stop edge (2 sync + 1) and key_valid one later
    v0 = vcnt;
    send(8'h1C);
    chk("lat_keycode", Keycode, 8'h04);
    chk("lat_stop_to_kc", chg_cyc - stop_cyc, 3);
    chk("lat_kc_to_valid", valid_cyc - chg_cyc, 1);
    chk("lat_valid_count", vcnt - v0, 1);
    send(8'hF0);
    send(8'h1C);
    chk("release_a", Keycode, 8'h00);

    // code, bad_par, bad_stop, expected Keycode, key_valid pulses, frame_err pulses
    add(8'h1C, 0, 0, 8'h04, 1, 0);
    add(8'h1C, 0, 0, 8'h04, 0, 0);
    add(8'hF0, 0, 0, 8'h04, 0, 0);
    add(8'h1C, 0, 0, 8'h00, 1, 0);
    add(8'hE0, 0, 0, 8'h00, 0, 0);
    add(8'h74, 0, 0, 8'h4F, 1, 0);
    add(8'hE0, 0, 0, 8'h4F, 0, 0);
    add(8'hF0, 0, 0, 8'h4F, 0, 0);
    add(8'h74, 0, 0, 8'h00, 1, 0);
    add(8'h23, 0, 0, 8'h07, 1, 0);
    add(8'hE0, 0, 0, 8'h07, 0, 0);
    add(8'h74, 0, 0, 8'h4F, 1, 0);
    add(8'hF0, 0, 0, 8'h4F, 0, 0);
    add(8'h23, 0, 0, 8'h4F, 0, 0);
    add(8'h1C, 1, 0, 8'h4F, 0, 1);
    add(8'h23, 0, 0, 8'h07, 1, 0);
    add(8'hE0, 0, 0, 8'h07, 0, 0);
    add(8'h74, 0, 1, 8'h07, 0, 1);
    add(8'h74, 0, 0, 8'h07, 0, 0);
    add(8'h5A, 0, 0, 8'h28, 1, 0);
    add(8'h29, 0, 0, 8'h2C, 1, 0);
    add(8'h1D, 0, 0, 8'h1A, 1, 0);
    add(8'h1B, 0, 0, 8'h16, 1, 0);
    add(8'hE0, 0, 0, 8'h16, 0, 0);
    add(8'h6B, 0, 0, 8'h50, 1, 0);
    add(8'hE0, 0, 0, 8'h50, 0, 0);
    add(8'h75, 0, 0, 8'h52, 1, 0);
    add(8'hE0, 0, 0, 8'h52, 0, 0);
    add(8'h72, 0, 0, 8'h51, 1, 0);
    add(8'h12, 0, 0, 8'h51, 0, 0);
    add(8'hF0, 0, 0, 8'h51, 0, 0);
    add(8'h1C, 0, 0, 8'h51, 0, 0);
    add(8'hE0, 0, 0, 8'h51, 0, 0);
    add(8'hF0, 0, 0, 8'h51, 0, 0);
    add(8'h72, 0, 0, 8'h00, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v0 = vcnt;
      e0 = ecnt;
      send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop, 11);
      chk($sformatf("row%0d_keycode", i), Keycode, tbl[i].exp_kc);
      chk($sformatf("row%0d_valid", i), vcnt - v0, tbl[i].dv);
      chk($sformatf("row%0d_err", i), ecnt - e0, tbl[i].de);
    end
    chk("prefix_ext_clear", dut.ext_q, 1'b0);
    chk("prefix_brk_clear", dut.brk_q, 1'b0);

    // Timeout: start + 4 data bits, then silence
    e0 = ecnt;
    send_frame(8'h29, 1'b0, 1'b0, 5);
    cycles(4850);
    chk("timeout_early_err", ecnt - e0, 0);
    cycles(300);
    chk("timeout_err", ecnt - e0, 1);
    chk("timeout_idle", dut.state_q, ST_IDLE);
    chk("timeout_keycode", Keycode, 8'h00);
    send(8'h29);
    chk("after_timeout_kc", Keycode, 8'h2C);
    chk("after_timeout_err", ecnt - e0, 1);

    // Reset mid-frame while D is held
    send(8'h23);
    chk("pre_reset_kc", Keycode, 8'h07);
    send_frame(8'h1C, 1'b0, 1'b0, 4);
    Reset = 1'b0;
    #1;
    chk("reset_mid_kc", Keycode, 8'h00);
    cycles(3);
    Reset = 1'b1;
    cycles(5);
    v0 = vcnt;
    send(8'h1C);
    chk("post_reset_kc", Keycode, 8'h04);
    chk("post_reset_valid", vcnt - v0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
